multi_button_debounce_scheduler: RTL and testbench
==================================================

# multi_button_debounce_scheduler

Debounces N independent button inputs using a single shared stability counter instead of one timer per input. A round-robin scheduler grants the counter to one input at a time, namely one whose raw level differs from its debounced level. The counter then times that input's stability window and commits the new level, with a one-cycle edge pulse, once the window completes. The block sits between the per-pin synchronizers and the user logic and replaces per-button debouncer instances on boards with many buttons.

## Interface
- `N`, default 4: number of button inputs; N ≥ 1.
- `WAIT`, default 1_999_999: stability window in clock cycles; WAIT ≥ 1.
- `CW`, derived as clog2(WAIT): counter width, minimum 1.
- `IW`, derived as clog2(N): owner index width, minimum 1.
- `clk` in, 1: single system clock; all logic is on the rising edge.
- `reset` in, 1: synchronous, active-high.
- `noisy` in, N: raw button levels, already synchronized to `clk`.
- `debounced` out, N: committed stable levels, registered.
- `rise` out, N: one-cycle pulse when `debounced[i]` goes 0→1.
- `fall` out, N: one-cycle pulse when `debounced[i]` goes 1→0.
- `busy` out, 1: high while the counter is granted, i.e. state ≠ IDLE; registered.
- `owner` out, IW: index of the input currently holding the counter. Holds its last value in IDLE.

## Operation
- `pending[i]` = `noisy[i]` XOR `debounced[i]`.
- Internal registers: state, `cnt` (CW bits), `ptr` (IW bits, the round-robin start point), `owner`.
- IDLE:
  - If `pending` = 0, stay in IDLE.
  - Otherwise pick the first set bit searching `ptr`, `ptr`+1, …, wrapping N-1→0.
  - Load `owner` with that index, set `cnt` = 0, go to COUNT.
- COUNT, evaluated every edge:
  - If `noisy[owner]` = `debounced[owner]`, the glitch has reverted: abort. Go to IDLE, set `ptr` = (`owner`+1) mod N, emit no pulse.
  - Else if `cnt` = WAIT-1, go to COMMIT.
  - Else increment `cnt`.
- COMMIT:
  - Toggle `debounced[owner]`.
  - Assert `rise[owner]` or `fall[owner]` on the same edge, matching the new level.
  - Set `ptr` = (`owner`+1) mod N and go to IDLE.
  - The commit is unconditional because stability was already proven.
- Non-owner inputs are ignored while the counter is busy. Their pending state is re-evaluated in the next IDLE cycle, and only the level present at grant matters.
- `rise` and `fall` are registered. They are high for exactly one cycle and are never both high for the same index.
- Reset values: state IDLE, `debounced` 0, `rise` 0, `fall` 0, `busy` 0, `owner` 0, `ptr` 0, `cnt` 0.
- Reset asserted in any state, including mid-COUNT or COMMIT, returns every register to its reset value on that edge. No pulse is emitted. Counting restarts from scratch after release.

## Timing
- Call E0 the edge at which IDLE samples `pending[i]` = 1 and grants input i.
- If the input stays stable, COUNT occupies edges E1..E_WAIT and COMMIT ends at E_(WAIT+1).
- `debounced[i]` changes, and the pulse asserts, after E_(WAIT+1). That is WAIT+1 edges after the grant.
- `busy` is high for WAIT+1 cycles per commit.
- An abort at edge Ek (1 ≤ k ≤ WAIT) returns to IDLE after Ek. The next grant can occur at Ek+1.
- Minimum spacing between two consecutive commits is WAIT+2 cycles.
- Worst-case latency for a continuously pending input is N·(WAIT+2) cycles; round robin guarantees no starvation.
- N = 1: `ptr` and `owner` stay 0.

## Structure
- Shared package `debounce_pkg` holds:
  - the state encoding constants IDLE, COUNT, COMMIT (2-bit);
  - the clog2 width helper used for CW and IW.
- One sub-module, `rr_pick`: combinational round-robin first-set-bit finder taking `pending` and `ptr` and producing `valid` and `idx`. It is reused by future arbiters.

## Test plan
All scenarios use N=4, WAIT=3.
- **Clean press.** Drive `noisy[2]` 0→1 and hold; grant at E0. Expect `owner`=2, `busy` high 4 cycles, `debounced[2]`=1 and `rise[2]` high for one cycle after E4, `ptr`=3.
- **Glitch.** Drive `noisy[1]` high for 2 cycles, then low. Expect an abort at E2 (`noisy[1]` has reverted to the debounced level by E2), no `debounced` change, no pulse, `ptr`=2.
- **Simultaneous inputs.** With `ptr`=0, raise `noisy[0]` and `noisy[3]` on the same cycle. Expect input 0 committed first and input 3 granted the cycle after returning to IDLE. `debounced[3]` rises 5 cycles after `debounced[0]`.
- **Release and wrap-around.** Start with `ptr`=3 and `debounced[3]`=1, then drive `noisy[3]` →0. Expect `fall[3]` pulse, `debounced[3]`=0, `ptr` wraps to 0.
- **Reset mid-count.** Assert `reset` at E2 of a grant on input 2. Expect all outputs 0 the next cycle and no pulse. After release, with `noisy[2]` still 1, expect a full fresh window: `rise[2]` after E4 of the new grant.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the button debounce blocks: scheduler state
// encoding and the width helper used to size counters and indices.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Ceiling log2, floored at 1 so single-entry fields still get a bit.
    function automatic int clog2_min1(input int v);
        int w;
        w = 0;
        while ((1 << w) < v) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set bit of pending at or after ptr,
// wrapping from N-1 back to 0.
module rr_pick
    import debounce_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    function automatic int wrap(input int a);
        return (a >= N) ? a - N : a;
    endfunction

    logic [IW-1:0] j;

    // Scan from the far end so the candidate closest to ptr is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'(wrap(int'(ptr) + k));
            if (pending[j]) begin
                valid = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/multi_button_debounce_scheduler.sv
// N-input debouncer sharing one stability counter, granted round-robin to
// whichever input currently disagrees with its committed level.
module multi_button_debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int N    = 4,
    parameter int WAIT = 1_999_999,
    localparam int CW  = clog2_min1(WAIT),
    localparam int IW  = clog2_min1(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  noisy,
    output logic [N-1:0]  debounced,
    output logic [N-1:0]  rise,
    output logic [N-1:0]  fall,
    output logic          busy,
    output logic [IW-1:0] owner
);

    localparam logic [IW-1:0] LAST    = IW'(N - 1);
    localparam logic [CW-1:0] CNT_END = CW'(WAIT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_d;
    logic [N-1:0]  deb_d, rise_d, fall_d;
    logic [N-1:0]  pending;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] owner_nxt;

    assign pending   = noisy ^ debounced;
    assign owner_nxt = (owner == LAST) ? '0 : owner + 1'b1;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .pending (pending),
        .ptr     (ptr_q),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            owner     <= '0;
            debounced <= '0;
            rise      <= '0;
            fall      <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            owner     <= owner_d;
            debounced <= deb_d;
            rise      <= rise_d;
            fall      <= fall_d;
            busy      <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner;
        deb_d   = debounced;
        rise_d  = '0;
        fall_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                // Owner back at its committed level means the edge was a glitch.
                if (!pending[owner]) begin
                    ptr_d   = owner_nxt;
                    state_d = IDLE;
                end else if (cnt_q == CNT_END) begin
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMMIT: begin
                deb_d[owner] = ~debounced[owner];
                if (~debounced[owner]) rise_d[owner] = 1'b1;
                else                   fall_d[owner] = 1'b1;
                ptr_d   = owner_nxt;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multi_button_debounce_scheduler.sv
// Bench for the shared-counter debouncer: directed table, corner sequences and
// randomized inputs against a grant/age based reference model.
module tb_multi_button_debounce_scheduler;

    localparam int N    = 4;
    localparam int WAIT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] noisy = '0;
    logic [3:0] debounced, rise, fall;
    logic       busy;
    logic [1:0] owner;

    multi_button_debounce_scheduler #(.N(N), .WAIT(WAIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .noisy     (noisy),
        .debounced (debounced),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: an input is granted, ages one per edge, aborts if it
    // reverts within WAIT edges, and commits on edge WAIT+1.
    logic [3:0] m_deb = '0, m_rise = '0, m_fall = '0;
    bit         m_busy = 0;
    int         m_age = 0, m_owner = 0, m_ptr = 0;

    task automatic model_step();
        bit found;
        m_rise = '0;
        m_fall = '0;
        if (reset) begin
            m_deb = '0; m_busy = 0; m_age = 0; m_owner = 0; m_ptr = 0;
        end else if (!m_busy) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!found && noisy[j] != m_deb[j]) begin
                    found = 1; m_owner = j; m_busy = 1; m_age = 0;
                end
            end
        end else begin
            m_age++;
            if (m_age <= WAIT) begin
                if (noisy[m_owner] == m_deb[m_owner]) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end else begin
                m_deb[m_owner] = ~m_deb[m_owner];
                if (m_deb[m_owner]) m_rise[m_owner] = 1'b1;
                else                m_fall[m_owner] = 1'b1;
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] nz);
        @(negedge clk);
        reset = r;
        noisy = nz;
        @(posedge clk);
        model_step();
        #1;
        check("model", {debounced, rise, fall, busy, owner},
              {m_deb, m_rise, m_fall, m_busy, 2'(m_owner)});
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] nz;
        logic [3:0] deb, ris, fal;
        logic       bsy;
        logic [1:0] own;
    } vec_t;

    vec_t tbl[12];
    int   r0, r3, nrise, nfall;

    initial begin
        // Clean press on input 2, then a 2-cycle glitch on input 1.
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2};
        tbl[2]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2};
        tbl[3]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2};
        tbl[4]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2};
        tbl[5]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd2};
        tbl[6]  = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd2};
        tbl[7]  = '{1'b0, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd1};
        tbl[8]  = '{1'b0, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd1};
        tbl[9]  = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd1};
        tbl[10] = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd1};
        tbl[11] = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd1};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].nz);
            check($sformatf("tbl[%0d]", i), {debounced, rise, fall, busy, owner},
                  {tbl[i].deb, tbl[i].ris, tbl[i].fal, tbl[i].bsy, tbl[i].own});
            if (i == 6) check("press_ptr", 32'(dut.ptr_q), 32'd3);
        end
        check("glitch_ptr", 32'(dut.ptr_q), 32'd2);

        // Simultaneous inputs 0 and 3 from ptr=0.
        step(1'b1, 4'b0000);
        r0 = -1; r3 = -1; nrise = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 4'b1001);
            if (rise[0]) begin r0 = i; nrise++; end
            if (rise[3]) begin r3 = i; nrise++; end
        end
        check("simul_first", 32'(r0), 32'd4);
        check("simul_gap", 32'(r3 - r0), 32'd5);
        check("simul_pulses", 32'(nrise), 32'd2);

        // Short glitch on input 2 moves ptr to 3, then release input 3.
        step(1'b0, 4'b1101);
        step(1'b0, 4'b1001);
        check("wrap_ptr_pre", 32'(dut.ptr_q), 32'd3);
        nfall = 0; nrise = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b0001);
            if (fall[3]) nfall++;
            if (rise != 0) nrise++;
        end
        check("wrap_fall", 32'(nfall), 32'd1);
        check("wrap_deb", 32'(debounced), 32'b0001);
        check("wrap_ptr", 32'(dut.ptr_q), 32'd0);
        check("wrap_norise", 32'(nrise), 32'd0);

        // Reset at E2 of a grant on input 2, then a fresh full window.
        step(1'b0, 4'b0101);
        step(1'b0, 4'b0101);
        step(1'b1, 4'b0101);
        check("rst_outs", {debounced, rise, fall, busy, owner}, 32'd0);
        check("rst_ptr", 32'(dut.ptr_q), 32'd0);
        r0 = -1; nrise = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b0100);
            if (rise[2]) begin if (r0 < 0) r0 = i; nrise++; end
        end
        check("rst_fresh_rise", 32'(r0), 32'd4);
        check("rst_fresh_count", 32'(nrise), 32'd1);

        // Randomized bursty inputs with occasional reset.
        begin
            logic [3:0] nz;
            nz = noisy;
            for (int i = 0; i < 3000; i++) begin
                for (int b = 0; b < N; b++)
                    if ($urandom_range(0, 5) == 0) nz[b] = ~nz[b];
                step(($urandom_range(0, 199) == 0), nz);
                check("pulse_excl", 32'(rise & fall), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
